// File: rtl/branch_pkg.sv
// Shared types for the branch condition unit: condition-code encodings and FSM states.
package branch_pkg;

    localparam logic [2:0] CondEncB   = 3'b000;
    localparam logic [2:0] CondEncBeq = 3'b001;
    localparam logic [2:0] CondEncBne = 3'b010;
    localparam logic [2:0] CondEncBlt = 3'b011;
    localparam logic [2:0] CondEncBle = 3'b100;

    typedef enum logic [2:0] {
        CondB   = CondEncB,
        CondBeq = CondEncBeq,
        CondBne = CondEncBne,
        CondBlt = CondEncBlt,
        CondBle = CondEncBle
    } cond_e;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: decides taken/illegal from a condition code and {Z,N,V}.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken,
    output logic       illegal
);

    logic flag_z;
    logic flag_n;
    logic flag_v;

    assign {flag_z, flag_n, flag_v} = flags;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cond)
            CondEncB:   taken = 1'b1;
            CondEncBeq: taken = flag_z;
            CondEncBne: taken = ~flag_z;
            CondEncBlt: taken = flag_n ^ flag_v;
            CondEncBle: taken = (flag_n ^ flag_v) | flag_z;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: stores ALU flags, evaluates branch requests, returns taken and next PC.
// Define BRANCH_COND_STATS_EN to add saturating taken/not-taken counters.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld_status,
    input  logic             z_in,
    input  logic             n_in,
    input  logic             v_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cond,
    input  logic [PC_W-1:0]  req_pc,
    input  logic [IMM_W-1:0] req_imm,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [PC_W-1:0]  resp_next_pc,
    output logic             resp_illegal,
    output logic [2:0]       status_q
`ifdef BRANCH_COND_STATS_EN
    ,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      not_taken_cnt
`endif
);

    state_e           state_q, state_d;
    logic [2:0]       cond_q;
    logic [PC_W-1:0]  pc_q;
    logic [IMM_W-1:0] imm_q;
    logic [2:0]       flags_q;
    logic [PC_W-1:0]  imm_ext;
    logic             eval_taken;
    logic             eval_illegal;
    logic             accept;
    logic             resp_fire;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign accept     = req_valid & req_ready;
    assign resp_fire  = resp_valid & resp_ready;
    assign imm_ext    = PC_W'($signed(imm_q));

    branch_cond_eval u_eval (
        .cond    (cond_q),
        .flags   (flags_q),
        .taken   (eval_taken),
        .illegal (eval_illegal)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StEval;
            StEval:  state_d = StDone;
            StDone:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            status_q     <= 3'b000;
            cond_q       <= 3'b000;
            pc_q         <= '0;
            imm_q        <= '0;
            flags_q      <= 3'b000;
            resp_taken   <= 1'b0;
            resp_next_pc <= '0;
            resp_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_status) begin
                status_q <= {z_in, n_in, v_in};
            end
            if (accept) begin
                cond_q  <= req_cond;
                pc_q    <= req_pc;
                imm_q   <= req_imm;
                // A load on the accept edge bypasses the stale status register.
                flags_q <= ld_status ? {z_in, n_in, v_in} : status_q;
            end
            if (state_q == StEval) begin
                resp_taken   <= eval_taken;
                resp_illegal <= eval_illegal;
                resp_next_pc <= pc_q + PC_W'(1) + (eval_taken ? imm_ext : '0);
            end
        end
    end

`ifdef BRANCH_COND_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_cnt     <= 16'h0000;
            not_taken_cnt <= 16'h0000;
        end else if (resp_fire) begin
            if (resp_taken) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'h0001;
            end else begin
                if (not_taken_cnt != 16'hFFFF) not_taken_cnt <= not_taken_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer side of the ALU status interface.
- Captures the Z/N/V flags the ALU produces into a 3-bit status register on a load strobe from the controller FSM.
- Accepts branch requests over a valid/ready handshake, evaluates the condition code against the stored flags, and returns taken/not-taken plus the next PC.
- Sits between the ALU/status path and the PC register in the datapath.

Parameters:
PC_W, 9, width of program counter (modulo-2^PC_W arithmetic)
IMM_W, 8, width of signed branch offset (sign-extended to PC_W)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  synchronous reset, active-low; sampled on clk rising edge
ld_status  input  1  load Z/N/V into status register this cycle
z_in  input  1  ALU zero flag
n_in  input  1  ALU negative flag
v_in  input  1  ALU overflow flag
req_valid  input  1  branch request valid
req_ready  output  1  unit can accept request (IDLE only)
req_cond  input  3  condition code
req_pc  input  PC_W  PC of the branch instruction
req_imm  input  IMM_W  signed offset
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_taken  output  1  branch taken
resp_next_pc  output  PC_W  next PC
resp_illegal  output  1  condition code not defined
status_q  output  3  {Z,N,V} currently held

Behaviour:
- Reset (reset_n=0 at rising edge):
  - status_q=3'b000.
  - FSM state is IDLE.
  - req_ready=1 after reset releases.
  - resp_valid=0, resp_taken=0, resp_next_pc=0, resp_illegal=0.
  - Reset overrides everything in the same cycle, including mid-EVAL/DONE. An in-flight response is discarded.
- Status register:
  - On ld_status=1, status_q <= {z_in,n_in,v_in} at the next edge.
  - Otherwise status_q holds.
  - Loads are allowed in any FSM state.
- Handshake: a request is accepted when req_valid && req_ready. Inputs are captured at that edge.
- FSM:
  - IDLE: req_ready=1. On accept, go to EVAL.
  - EVAL: req_ready=0. Compute taken/next_pc from the captured request and the flags. Go to DONE.
  - DONE: resp_valid=1, response outputs stable. On resp_ready=1, go to IDLE. Otherwise stay; all resp_* outputs hold.
- Latency:
  - Accept at edge T; resp_valid is high from T+2.
  - Minimum request spacing is 3 cycles. The next accept can happen at the edge after the resp_ready handshake.
- Flag source for evaluation: the flags sampled at the accept edge.
  - If ld_status=1 at the accept edge, the new {z_in,n_in,v_in} are used (bypass), not the old status_q.
  - Loads during EVAL/DONE do not affect the pending result.
- Condition codes:
  - 000 B: always taken.
  - 001 BEQ: Z.
  - 010 BNE: !Z.
  - 011 BLT: N^V.
  - 100 BLE: (N^V)|Z.
  - 101-111: resp_illegal=1, not taken.
- Arithmetic:
  - Taken: next_pc = req_pc + 1 + sext(req_imm).
  - Not taken: next_pc = req_pc + 1.
  - Both truncated to PC_W bits, so wrap-around is silent. Example: 0x1FF + 1 = 0x000.
- req_valid while not IDLE is ignored, and the requester must hold it.
- resp_ready while not in DONE is ignored.

Optional Feature:
- Macro: BRANCH_COND_STATS_EN.
- When defined:
  - Adds outputs taken_cnt[15:0] and not_taken_cnt[15:0], both reset to 0.
  - On each resp_valid && resp_ready handshake, exactly one counter increments. Illegal codes count as not taken.
  - Counters saturate at 16'hFFFF and do not wrap.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg:
  - Typedef enum cond_e (B, BEQ, BNE, BLT, BLE).
  - Typedef enum state_e (IDLE, EVAL, DONE).
  - Localparams for the condition encodings.
- One sub-module, branch_cond_eval: combinational, takes cond and {Z,N,V}, returns taken and illegal. It is reusable by the controller decoder.

Test Plan:
- Reset mid-operation: accept a request, assert reset_n=0 in EVAL. Next cycle resp_valid=0, req_ready=1, status_q=000.
- Equality branch: ld_status with z=1; next cycle request BEQ, pc=0x010, imm=0x05. At T+2 resp_valid=1, taken=1, next_pc=0x016. Then BNE with the same values gives taken=0, next_pc=0x011.
- Signed less-than: load n=1,v=0, request BLT, pc=0x020, imm=0xFE (-2). Result taken=1, next_pc=0x01F. Load n=1,v=1 and repeat: taken=0, next_pc=0x021.
- Bypass and wrap:
  - Assert ld_status (z=1) on the same edge a BLE is accepted while status_q=000. Result must use z=1: taken=1.
  - pc=0x1FF, imm=0x00 with taken gives next_pc=0x000.
- Backpressure and illegal code:
  - Hold resp_ready=0 for 5 cycles in DONE. Outputs must be stable and req_ready=0; a second req_valid must not be accepted.
  - cond=111: resp_illegal=1, taken=0, next_pc=pc+1.
- Stats (BRANCH_COND_STATS_EN defined): 3 taken and 2 not-taken handshakes give taken_cnt=3, not_taken_cnt=2. Forcing taken_cnt to 0xFFFF and completing one more taken branch leaves it at 0xFFFF.
